// File: rtl/bound_flasher_engine.sv
// Parametrised bound-flasher engine: sequencing FSM, lamp-count register, step-rate prescaler
// and flick kickback driving an N-lamp thermometer bar.
module bound_flasher_engine #(
  parameter int unsigned NUM_LEDS = 16,
  parameter int unsigned LO_B     = 6,
  parameter int unsigned HI_B     = 11,
  parameter int unsigned STEP_DIV = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flick,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          led_bhv,
  output logic [3:0]          cur_st,
  output logic                done
);

  localparam int unsigned CntW = $clog2(NUM_LEDS + 1);
  localparam int unsigned DivW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [CntW-1:0] CntFull = CntW'(NUM_LEDS);
  localparam logic [CntW-1:0] CntLo   = CntW'(LO_B);
  localparam logic [CntW-1:0] CntHi   = CntW'(HI_B);
  localparam logic [DivW-1:0] DivLast = DivW'(STEP_DIV - 1);

  if (NUM_LEDS < 4 || NUM_LEDS > 64) begin : g_chk_num_leds
    $error("bound_flasher_engine: NUM_LEDS must be in 4..64");
  end
  if (LO_B == 0 || LO_B >= HI_B) begin : g_chk_lo_b
    $error("bound_flasher_engine: need 0 < LO_B < HI_B");
  end
  if (HI_B >= NUM_LEDS) begin : g_chk_hi_b
    $error("bound_flasher_engine: need HI_B < NUM_LEDS");
  end
  if (STEP_DIV < 1) begin : g_chk_step_div
    $error("bound_flasher_engine: STEP_DIV must be >= 1");
  end

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StUpFull = 4'd1,
    StDnLo   = 4'd2,
    StUpMid  = 4'd3,
    StDnZero = 4'd4,
    StUpLo   = 4'd5,
    StDnEnd  = 4'd6,
    StKbZero = 4'd7,
    StKbLo   = 4'd8
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DivW-1:0] div_q, div_d;
  logic            done_q, done_d;

  logic            tick;
  logic            rising;
  logic            kick_full;
  logic            kick_mid;
  logic [CntW-1:0] target;
  state_e          adv_st;

  // Per-state target count, direction and the state entered once the target is reached.
  always_comb begin : p_decode
    target = '0;
    rising = 1'b0;
    adv_st = StIdle;
    unique case (state_q)
      StUpFull: begin
        target = CntFull;
        rising = 1'b1;
        adv_st = StDnLo;
      end
      StDnLo: begin
        target = CntLo;
        adv_st = StUpMid;
      end
      StUpMid: begin
        target = CntHi;
        rising = 1'b1;
        adv_st = StDnZero;
      end
      StDnZero: begin
        target = '0;
        adv_st = StUpLo;
      end
      StUpLo: begin
        target = CntLo;
        rising = 1'b1;
        adv_st = StDnEnd;
      end
      StDnEnd: begin
        target = '0;
        adv_st = StIdle;
      end
      StKbZero: begin
        target = '0;
        adv_st = StUpFull;
      end
      StKbLo: begin
        target = CntLo;
        adv_st = StUpMid;
      end
      default: begin
        target = '0;
        rising = 1'b0;
        adv_st = StIdle;
      end
    endcase
  end

  assign tick      = (state_q != StIdle) && (div_q == DivLast);
  assign kick_full = (state_q == StUpFull) && ((cnt_q == CntLo) || (cnt_q == CntHi));
  assign kick_mid  = (state_q == StUpMid) && (cnt_q == CntHi);

  always_comb begin : p_next
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    done_d  = 1'b0;
    if (state_q == StIdle) begin
      div_d = '0;
      // The done cycle swallows a start request so a held flick cannot chain runs back-to-back.
      if (flick && !done_q) begin
        state_d = StUpFull;
      end
    end else begin
      div_d = tick ? '0 : div_q + DivW'(1);
      if (tick) begin
        if (flick && kick_full) begin
          state_d = StKbZero;
        end else if (flick && kick_mid) begin
          state_d = StKbLo;
        end else if (cnt_q == target) begin
          state_d = adv_st;
          done_d  = (state_q == StDnEnd);
        end else if (rising) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_regs
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      done_q  <= done_d;
    end
  end

  always_comb begin : p_led
    led = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      led[i] = (CntW'(i) < cnt_q);
    end
  end

  assign led_bhv = (state_q == StIdle) ? 2'd3 : (rising ? 2'd1 : 2'd0);
  assign cur_st  = state_q;
  assign done    = done_q;

  cnt_range_a: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CntFull);
  done_idle_a: assert property (@(posedge clk) disable iff (!rst_n) done_q |-> state_q == StIdle);

endmodule

// File: tb/tb_bound_flasher_engine.sv
// Bench for bound_flasher_engine: two instances (default and slow/narrow) share clock, reset and
// flick, each checked every cycle against a table-driven sequence model.
module tb_bound_flasher_engine;

  localparam int NA = 16, LA = 6, HA = 11, DA = 1;
  localparam int NB = 8,  LB = 2, HB = 5,  DB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flick = 1'b0;
  logic [NA-1:0] led_a;
  logic [1:0]    bhv_a;
  logic [3:0]    st_a;
  logic          done_a;
  logic [NB-1:0] led_b;
  logic [1:0]    bhv_b;
  logic [3:0]    st_b;
  logic          done_b;

  always #5 clk = ~clk;

  bound_flasher_engine #(.NUM_LEDS(NA), .LO_B(LA), .HI_B(HA), .STEP_DIV(DA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flick(flick),
    .led(led_a), .led_bhv(bhv_a), .cur_st(st_a), .done(done_a)
  );

  bound_flasher_engine #(.NUM_LEDS(NB), .LO_B(LB), .HI_B(HB), .STEP_DIV(DB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flick(flick),
    .led(led_b), .led_bhv(bhv_b), .cur_st(st_b), .done(done_b)
  );

  typedef struct packed {
    int   st;
    int   cnt;
    int   dv;
    logic done;
  } mdl_t;

  mdl_t ma, mb;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Sequence table: phase target count, direction and successor phase.
  function automatic int tgt_of(input int st, input int n, input int lo, input int hi);
    case (st)
      1:       return n;
      2, 5, 8: return lo;
      3:       return hi;
      default: return 0;
    endcase
  endfunction

  function automatic bit rises(input int st);
    return (st == 1) || (st == 3) || (st == 5);
  endfunction

  function automatic int nxt_of(input int st);
    case (st)
      1: return 2;
      2: return 3;
      3: return 4;
      4: return 5;
      5: return 6;
      7: return 1;
      8: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic mdl_t model_step(input mdl_t m, input bit fl, input int n, input int lo,
                                      input int hi, input int sd);
    mdl_t r;
    bit   tk;
    r      = m;
    r.done = 1'b0;
    if (m.st == 0) begin
      r.dv = 0;
      if (fl && !m.done) r.st = 1;
      return r;
    end
    tk   = (m.dv == sd - 1);
    r.dv = tk ? 0 : m.dv + 1;
    if (!tk) return r;
    if (fl && m.st == 1 && (m.cnt == lo || m.cnt == hi)) r.st = 7;
    else if (fl && m.st == 3 && m.cnt == hi) r.st = 8;
    else if (m.cnt == tgt_of(m.st, n, lo, hi)) begin
      r.st   = nxt_of(m.st);
      r.done = (m.st == 6);
    end else if (rises(m.st)) r.cnt = m.cnt + 1;
    else r.cnt = m.cnt - 1;
    return r;
  endfunction

  function automatic logic [63:0] exp_led(input int cnt);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < cnt; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] exp_bhv(input int st);
    if (st == 0) return 64'd3;
    return rises(st) ? 64'd1 : 64'd0;
  endfunction

  task automatic compare_all();
    check_eq("a_led",  64'(led_a),  exp_led(ma.cnt));
    check_eq("a_bhv",  64'(bhv_a),  exp_bhv(ma.st));
    check_eq("a_st",   64'(st_a),   64'(ma.st));
    check_eq("a_done", 64'(done_a), 64'(ma.done));
    check_eq("b_led",  64'(led_b),  exp_led(mb.cnt));
    check_eq("b_bhv",  64'(bhv_b),  exp_bhv(mb.st));
    check_eq("b_st",   64'(st_b),   64'(mb.st));
    check_eq("b_done", 64'(done_b), 64'(mb.done));
  endtask

  // Called at a negedge: drive flick, take the edge, advance both models, check at next negedge.
  task automatic tick_clk(input bit fl);
    flick = fl;
    @(posedge clk);
    ma = model_step(ma, fl, NA, LA, HA, DA);
    mb = model_step(mb, fl, NB, LB, HB, DB);
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  // Called at a negedge: asserts reset mid-cycle and checks outputs before any clock edge.
  task automatic do_reset();
    flick = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_a_led", 64'(led_a),  64'd0);
    check_eq("rst_a_bhv", 64'(bhv_a),  64'd3);
    check_eq("rst_a_st",  64'(st_a),   64'd0);
    check_eq("rst_a_dn",  64'(done_a), 64'd0);
    check_eq("rst_b_led", 64'(led_b),  64'd0);
    check_eq("rst_b_bhv", 64'(bhv_b),  64'd3);
    ma = '0;
    mb = '0;
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           c0;
    bit           found;
    logic [63:0]  max_led;
    bit           seen_kb;
    int           chg[$];
    logic [NB-1:0] prev_b;
    bit           fl;
    int           mode;

    ma = '0;
    mb = '0;
    @(negedge clk);
    do_reset();

    // Full sequence from a single flick; done latency measured on the DUT.
    tick_clk(1'b1);
    check_eq("start_st", 64'(st_a), 64'd1);
    c0    = cyc;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick_clk(1'b0);
      if (done_a) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("done_seen", 64'(found), 64'd1);
    check_eq("done_latency", 64'(cyc - c0), 64'd60);

    // Flick held high: repeated kickback at LO_B keeps the bar at or below 6 lamps.
    do_reset();
    max_led = '0;
    seen_kb = 1'b0;
    repeat (120) begin
      tick_clk(1'b1);
      if (64'(led_a) > max_led) max_led = 64'(led_a);
      if (st_a == 4'd7) seen_kb = 1'b1;
    end
    check_eq("hold_max_led", max_led, 64'h003F);
    check_eq("hold_kb_seen", 64'(seen_kb), 64'd1);

    // Flick on the UP_MID tick at HI_B only.
    do_reset();
    tick_clk(1'b1);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      fl = (ma.st == 3) && (ma.cnt == HA);
      tick_clk(fl);
      if (fl) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("mid_hi_seen", 64'(found), 64'd1);
    check_eq("kb_lo_entry", 64'(st_a), 64'd8);
    check_eq("kb_lo_led", 64'(led_a), 64'h07FF);
    repeat (11) tick_clk(1'b0);
    check_eq("mid_dwell_st", 64'(st_a), 64'd3);
    check_eq("mid_dwell_led", 64'(led_a), 64'h07FF);
    tick_clk(1'b0);
    check_eq("dn_zero_st", 64'(st_a), 64'd4);

    // Slow instance: step spacing and off-tick flicks at LO_B.
    do_reset();
    tick_clk(1'b1);
    c0     = cyc;
    prev_b = led_b;
    chg.delete();
    repeat (14) begin
      fl = (mb.st == 1) && (mb.cnt == LB) && (mb.dv != DB - 1);
      tick_clk(fl);
      if (led_b != prev_b) chg.push_back(cyc - c0);
      prev_b = led_b;
    end
    check_eq("b_chg_count", 64'(chg.size()), 64'd3);
    if (chg.size() >= 3) begin
      check_eq("b_step1", 64'(chg[0]), 64'd4);
      check_eq("b_step2", 64'(chg[1] - chg[0]), 64'd4);
      check_eq("b_step3", 64'(chg[2] - chg[1]), 64'd4);
    end
    check_eq("b_no_kick_st", 64'(st_b), 64'd1);
    check_eq("b_no_kick_led", 64'(led_b), 64'h07);

    // Async reset in DN_ZERO at 7 lamps, then restart.
    do_reset();
    tick_clk(1'b1);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick_clk(1'b0);
      if (ma.st == 4 && ma.cnt == 7) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("dnz7_seen", 64'(found), 64'd1);
    check_eq("dnz7_led", 64'(led_a), 64'h007F);
    do_reset();
    tick_clk(1'b1);
    check_eq("restart_st", 64'(st_a), 64'd1);
    check_eq("restart_led", 64'(led_a), 64'd0);

    // Flick in the done cycle is swallowed; the next one restarts.
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick_clk(1'b0);
      if (done_a) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("done2_seen", 64'(found), 64'd1);
    tick_clk(1'b1);
    check_eq("done_flick_st", 64'(st_a), 64'd0);
    tick_clk(1'b1);
    check_eq("post_done_st", 64'(st_a), 64'd1);

    // Randomised flick density with occasional asynchronous resets.
    do_reset();
    for (int blk = 0; blk < 20; blk++) begin
      mode = $urandom_range(0, 2);
      for (int k = 0; k < 200; k++) begin
        if ($urandom_range(0, 599) == 0) begin
          do_reset();
        end else begin
          case (mode)
            0:       fl = ($urandom_range(0, 99) == 0);
            1:       fl = ($urandom_range(0, 19) == 0);
            default: fl = ($urandom_range(0, 2) == 0);
          endcase
          tick_clk(fl);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bound_flasher_engine.md
Name: bound_flasher_engine

Overview:
- Parametrised successor to the fixed 16-lamp bound-flasher decoder. It owns the whole sequence: state machine, lamp-count register, step-rate prescaler and flick kickback.
- Drives an N-lamp thermometer bar through the six-phase bound sequence with programmable bounds.
- Exports the per-state direction code (3 = idle, 1 = rising, 0 = falling) for downstream consumers.

Parameters:
NUM_LEDS, 16, number of lamps; legal range 4..64
LO_B, 6, lower bound as a lit-lamp count; requires 0 < LO_B < HI_B
HI_B, 11, upper bound as a lit-lamp count; requires HI_B < NUM_LEDS
STEP_DIV, 1, clocks per lamp step; must be >= 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flick  in  1  start request in IDLE; kickback request at bound points
led  out  NUM_LEDS  thermometer bar; led[i] = (i < cnt)
led_bhv  out  2  3 = idle, 1 = rising state, 0 = falling state
cur_st  out  4  current state encoding, for debug and coverage
done  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, cnt = 0, tick counter = 0.
  - led = 0, led_bhv = 3, done = 0.
- cnt width = $clog2(NUM_LEDS+1). led is registered-equivalent, derived from cnt only. cnt never leaves 0..NUM_LEDS.
- Prescaler:
  - Active in every state except IDLE; held at 0 in IDLE.
  - Counts 0..STEP_DIV-1. tick is asserted when the count equals STEP_DIV-1, then the count wraps to 0.
  - STEP_DIV = 1 gives a tick every cycle.
- State codes, with target count and direction:
  - IDLE = 0
  - UP_FULL = 1: target NUM_LEDS, rising
  - DN_LO = 2: target LO_B, falling
  - UP_MID = 3: target HI_B, rising
  - DN_ZERO = 4: target 0, falling
  - UP_LO = 5: target LO_B, rising
  - DN_END = 6: target 0, falling
  - KB_ZERO = 7: target 0, falling
  - KB_LO = 8: target LO_B, falling
- IDLE: flick = 1 on any clock moves to UP_FULL on the next edge. cnt stays 0. Flick is not tick-gated here.
- Each tick outside IDLE applies the first matching rule, in this priority:
  1. Kickback:
     - In UP_FULL with (cnt == LO_B or cnt == HI_B) and flick = 1: go to KB_ZERO, cnt unchanged.
     - In UP_MID with cnt == HI_B and flick = 1: go to KB_LO, cnt unchanged.
  2. Target reached (cnt == target): advance, cnt unchanged (one-step dwell).
     - UP_FULL -> DN_LO -> UP_MID -> DN_ZERO -> UP_LO -> DN_END -> IDLE.
     - KB_ZERO -> UP_FULL.
     - KB_LO -> UP_MID.
  3. Otherwise: cnt += 1 in a rising state, cnt -= 1 in a falling state.
- Flick is ignored on non-tick cycles and at non-bound counts. Kickback is not checked in DN_*, UP_LO or KB_* states.
- Repeated kickback is unlimited: each return to a bound with flick = 1 kicks back again.
- done = 1 for exactly one cycle, on the edge DN_END -> IDLE.
- A flick in that same cycle is ignored. A flick on the following cycle restarts the sequence.
- led_bhv and cur_st are combinational from state.
- Async reset mid-sequence returns immediately to the reset values. No partial-step carry-over.
- Parameter violations trigger an elaboration-time $error.

Test Plan:
1. Reset, then 1-cycle flick in IDLE (defaults, STEP_DIV = 1):
   - cnt sequence 0↑16, 16↓6, 6↑11, 11↓0, 0↑6, 6↓0.
   - done pulses exactly 60 clocks after UP_FULL entry; led_bhv follows 1/0/1/0/1/0, then 3.
2. Flick held high through UP_FULL:
   - At tick with cnt = 6, state goes to KB_ZERO and cnt falls to 0, then UP_FULL.
   - The loop repeats and led never exceeds 16'h003F while flick stays high.
3. Flick pulsed only on the tick where cnt = 11 in UP_MID:
   - State goes to KB_LO, cnt falls 11→6, back to UP_MID, reaches 11.
   - With flick low it dwells one tick, then enters DN_ZERO.
4. STEP_DIV = 4, NUM_LEDS = 8, LO_B = 2, HI_B = 5:
   - Each cnt change is separated by exactly 4 clocks.
   - Flick pulses that miss the tick cycle at cnt = 2 cause no kickback.
5. rst_n dropped asynchronously mid-DN_ZERO with cnt = 7:
   - led = 0, led_bhv = 3 and cur_st = 0 without waiting for a clock edge.
   - A subsequent flick restarts the sequence from 0.
6. Flick asserted in the done cycle -> stays IDLE. Flick on the next cycle -> UP_FULL entered, prescaler starts from 0.
